// File: rtl/aud_pkg.sv
// Shared types and constants for the audio output path (I2S transmit side).
package aud_pkg;

  localparam int AUD_DATA_W = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_SEND
  } i2s_tx_state_t;

  typedef logic signed [AUD_DATA_W-1:0] pcm_t;

endpackage

// File: rtl/aud_sync_edge.sv
// Multi-flop synchronizer for a slow asynchronous clock-like input, with a
// registered any-edge pulse and the matching registered level.
module aud_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_edge,
  output logic o_level
);

  logic [SYNC_STAGES-1:0] r_chain;
  logic                   r_level;
  logic                   r_edge;

  // r_level doubles as the "previous" sample, so o_edge and o_level line up:
  // on an edge pulse, o_level already holds the new value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_chain <= {SYNC_STAGES{RST_VAL}};
      r_level <= RST_VAL;
      r_edge  <= 1'b0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
      r_level <= r_chain[SYNC_STAGES-1];
      r_edge  <= r_chain[SYNC_STAGES-1] ^ r_level;
    end
  end

  assign o_edge  = r_edge;
  assign o_level = r_level;

endmodule

// File: rtl/aud_i2s_player.sv
// I2S mono player: serializes one PCM sample MSB-first on both slots, slaved to
// codec BCLK/DACLRCK. Optional volume shift when AUD_I2S_PLAYER_VOL_EN is defined.
module aud_i2s_player
  import aud_pkg::*;
#(
  parameter int DATA_W      = AUD_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic                     i_bclk,
  input  logic                     i_daclrck,
  input  logic signed [DATA_W-1:0] i_dac_data,
`ifdef AUD_I2S_PLAYER_VOL_EN
  input  logic [2:0]               i_vol,
`endif
  output logic                     o_aud_dacdat,
  output logic                     o_busy,
  output logic                     o_frame_tick
);

  localparam int CNT_W = $clog2(DATA_W);

  logic w_bclk_edge, w_bclk_level, w_bclk_fall;
  logic w_lrck_edge, w_lrck_level, w_lrck_fall;
  logic signed [DATA_W-1:0] w_new_sample;
  i2s_tx_state_t r_state, w_state_nxt;
  logic w_load, w_start, w_step, w_done;

  logic signed [DATA_W-1:0] r_sample;
  logic        [DATA_W-1:0] r_shift;
  logic        [CNT_W-1:0]  r_bit_cnt;
  logic                     r_dacdat;
  logic                     r_busy;
  logic                     r_frame_tick;

  aud_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_bclk (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_d     (i_bclk),
    .o_edge  (w_bclk_edge),
    .o_level (w_bclk_level)
  );

  aud_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_lrck (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_d     (i_daclrck),
    .o_edge  (w_lrck_edge),
    .o_level (w_lrck_level)
  );

  assign w_bclk_fall = w_bclk_edge & ~w_bclk_level;
  assign w_lrck_fall = w_lrck_edge & ~w_lrck_level;

`ifdef AUD_I2S_PLAYER_VOL_EN
  assign w_new_sample = i_en ? (i_dac_data >>> i_vol) : '0;
`else
  assign w_new_sample = i_en ? i_dac_data : '0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // An LRCK edge always wins: it restarts the slot and swallows a coincident BCLK fall.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_start     = 1'b0;
    w_step      = 1'b0;
    w_done      = 1'b0;
    if (w_lrck_edge) begin
      w_state_nxt = S_DELAY;
      w_load      = 1'b1;
    end else if (w_bclk_fall) begin
      unique case (r_state)
        S_DELAY: begin
          w_state_nxt = S_SEND;
          w_start     = 1'b1;
        end
        S_SEND: begin
          if (r_bit_cnt == '0) begin
            w_state_nxt = S_IDLE;
            w_done      = 1'b1;
          end else begin
            w_step = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sample     <= '0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_dacdat     <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_lrck_fall;
      if (w_lrck_fall) r_sample <= w_new_sample;
      if (w_load) begin
        r_shift <= w_lrck_fall ? w_new_sample : r_sample;
      end else if (w_start) begin
        r_dacdat  <= r_shift[DATA_W-1];
        r_bit_cnt <= CNT_W'(DATA_W-1);
        r_busy    <= 1'b1;
      end else if (w_step) begin
        r_shift   <= r_shift << 1;
        r_dacdat  <= r_shift[DATA_W-2];
        r_bit_cnt <= r_bit_cnt - CNT_W'(1);
      end else if (w_done) begin
        r_dacdat <= 1'b0;
        r_busy   <= 1'b0;
      end
    end
  end

  assign o_aud_dacdat = r_dacdat;
  assign o_busy       = r_busy;
  assign o_frame_tick = r_frame_tick;

endmodule

// File: tb/tb_aud_i2s_player.sv
// Directed bench for aud_i2s_player: slot-level model of the I2S stream,
// checked mid-bit on every BCLK period, plus literal word/tick expectations.
module tb_aud_i2s_player;
  import aud_pkg::*;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic en   = 1'b0;
  logic bclk = 1'b1;
  logic lrck = 1'b1;
  pcm_t data = '0;
`ifdef AUD_I2S_PLAYER_VOL_EN
  logic [2:0] vol = 3'd0;
`endif
  logic dacdat, busy, tick;

  always #5 clk = ~clk;

  aud_i2s_player #(.DATA_W(16), .SYNC_STAGES(2)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_bclk       (bclk),
    .i_daclrck    (lrck),
    .i_dac_data   (data),
`ifdef AUD_I2S_PLAYER_VOL_EN
    .i_vol        (vol),
`endif
    .o_aud_dacdat (dacdat),
    .o_busy       (busy),
    .o_frame_tick (tick)
  );

  int n_pass = 0;
  int n_total = 0;
  int tick_cnt = 0;

  // Model: per-slot view of the stream, indexed by BCLK falls since the LRCK edge.
  bit   m_active = 1'b0;
  int   m_k = 0;
  logic m_dat = 1'b0;
  logic m_busy = 1'b0;
  pcm_t m_latched = '0;
  pcm_t m_word = '0;
  logic [15:0] cap = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  task automatic model_edge(input bit left);
    if (left) begin
`ifdef AUD_I2S_PLAYER_VOL_EN
      m_latched = en ? (data >>> vol) : '0;
`else
      m_latched = en ? data : '0;
`endif
    end
    m_word   = m_latched;
    m_k      = 0;
    m_active = 1'b1;
  endtask

  task automatic model_fall();
    if (m_active && m_k < 17) begin
      m_k++;
      if (m_k <= 16) begin
        m_dat  = m_word[16-m_k];
        m_busy = 1'b1;
      end else begin
        m_dat  = 1'b0;
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    m_active  = 1'b0;
    m_k       = 0;
    m_dat     = 1'b0;
    m_busy    = 1'b0;
    m_latched = '0;
    m_word    = '0;
  endtask

  always @(negedge clk) if (tick === 1'b1) tick_cnt++;

  // Compare process: mid-bit (BCLK high phase) check of data and busy.
  always @(posedge bclk) begin
    if (!rst) begin
      chk("dacdat", {31'd0, dacdat}, {31'd0, m_dat});
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      if (m_active && m_k >= 1 && m_k <= 16) cap[16-m_k] = dacdat;
    end
  end

  task automatic do_fall(input bit chg, input logic lr);
    @(negedge clk);
    bclk = 1'b0;
    if (chg) begin
      lrck = lr;
      model_edge(lr == 1'b0);
    end else begin
      model_fall();
    end
    repeat (8) @(negedge clk);
    bclk = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic rst_fall();
    @(negedge clk);
    bclk = 1'b0;
    model_fall();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_dacdat", {31'd0, dacdat}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    bclk = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic run_slot(input bit left, input int nf, input int en_off_at, input int rst_at,
                          input logic [15:0] exp_word, input int exp_ticks, input string nm);
    int t0;
    t0  = tick_cnt;
    cap = '0;
    do_fall(1'b1, left ? 1'b0 : 1'b1);
    for (int k = 1; k < nf; k++) begin
      if (k == en_off_at) en = 1'b0;
      if (k == rst_at) rst_fall();
      else do_fall(1'b0, lrck);
    end
    chk({nm, "_word"}, {16'd0, cap}, {16'd0, exp_word});
    chk({nm, "_ticks"}, tick_cnt - t0, exp_ticks);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    chk("reset_dacdat", {31'd0, dacdat}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_tick", {31'd0, tick}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) do_fall(1'b0, lrck);
    chk("idle_ticks", tick_cnt, 0);

    en = 1'b1;
    data = 16'hA5C3;
    run_slot(1'b1, 32, -1, -1, 16'hA5C3, 1, "nom_left");
    chk("model_latch", {16'd0, m_latched}, 32'h0000A5C3);
    run_slot(1'b0, 32, -1, -1, 16'hA5C3, 0, "nom_right");

    data = 16'h3C5A;
    run_slot(1'b1, 6, -1, -1, 16'h3800, 1, "abort_left");
    run_slot(1'b0, 32, -1, -1, 16'h3C5A, 0, "abort_new");

    data = 16'h7FFF;
    run_slot(1'b1, 32, 5, -1, 16'h7FFF, 1, "en_left");
    run_slot(1'b0, 32, -1, -1, 16'h7FFF, 0, "en_right");
    data = 16'h5555;
    run_slot(1'b1, 32, -1, -1, 16'h0000, 1, "sil_left");
    run_slot(1'b0, 32, -1, -1, 16'h0000, 0, "sil_right");

    en = 1'b1;
    data = 16'hA5C3;
    run_slot(1'b1, 32, -1, -1, 16'hA5C3, 1, "pre_rst");
    run_slot(1'b0, 32, -1, 8, 16'hA400, 0, "rst_right");
    data = 16'h1234;
    run_slot(1'b1, 32, -1, -1, 16'h1234, 1, "post_rst");

`ifdef AUD_I2S_PLAYER_VOL_EN
    vol = 3'd3;
    data = 16'h8000;
    run_slot(1'b1, 32, -1, -1, 16'hF000, 1, "vol_left");
    vol = 3'd0;
    run_slot(1'b0, 32, -1, -1, 16'hF000, 0, "vol_right");
`endif

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
